// File: rtl/udp_eth_rx_port_demux.sv
// ============================================================================
// Module      : udp_eth_rx_port_demux
// Description : Steers UDP RX packets (metadata + payload) to one of
//               NUM_CHANNELS outputs by destination-port table lookup;
//               unmatched packets are drained. Optional statistics counters
//               are built when UDP_RX_DEMUX_STATS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module udp_eth_rx_port_demux #(
    parameter int DATA_WIDTH     = 256,
    parameter int KEEP_WIDTH     = DATA_WIDTH / 8,
    parameter int NUM_CHANNELS   = 4,
    parameter int IP_ADDR_WIDTH  = 32,
    parameter int UDP_PORT_WIDTH = 16,
    parameter int UDP_LEN_WIDTH  = 16,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                                     clk,
    input  logic                                     reset_n,

    input  logic                                     s_port_cfg_valid,
    output logic                                     s_port_cfg_ready,
    input  logic [$clog2(NUM_CHANNELS)-1:0]          s_port_cfg_index,
    input  logic [UDP_PORT_WIDTH-1:0]                s_port_cfg_port,
    input  logic                                     s_port_cfg_enable,

    input  logic                                     s_udp_meta_valid,
    output logic                                     s_udp_meta_ready,
    input  logic [IP_ADDR_WIDTH-1:0]                 s_udp_meta_ip_addr,
    input  logic [UDP_PORT_WIDTH-1:0]                s_udp_meta_dst_port,
    input  logic [UDP_PORT_WIDTH-1:0]                s_udp_meta_src_port,
    input  logic [UDP_LEN_WIDTH-1:0]                 s_udp_meta_data_len,

    input  logic                                     s_data_stream_tvalid,
    output logic                                     s_data_stream_tready,
    input  logic [DATA_WIDTH-1:0]                    s_data_stream_tdata,
    input  logic [KEEP_WIDTH-1:0]                    s_data_stream_tkeep,
    input  logic                                     s_data_stream_tfirst,
    input  logic                                     s_data_stream_tlast,

    output logic [NUM_CHANNELS-1:0]                  m_udp_meta_valid,
    input  logic [NUM_CHANNELS-1:0]                  m_udp_meta_ready,
    output logic [NUM_CHANNELS*IP_ADDR_WIDTH-1:0]    m_udp_meta_ip_addr,
    output logic [NUM_CHANNELS*UDP_PORT_WIDTH-1:0]   m_udp_meta_dst_port,
    output logic [NUM_CHANNELS*UDP_PORT_WIDTH-1:0]   m_udp_meta_src_port,
    output logic [NUM_CHANNELS*UDP_LEN_WIDTH-1:0]    m_udp_meta_data_len,

    output logic [NUM_CHANNELS-1:0]                  m_data_stream_tvalid,
    input  logic [NUM_CHANNELS-1:0]                  m_data_stream_tready,
    output logic [NUM_CHANNELS*DATA_WIDTH-1:0]       m_data_stream_tdata,
    output logic [NUM_CHANNELS*KEEP_WIDTH-1:0]       m_data_stream_tkeep,
    output logic [NUM_CHANNELS-1:0]                  m_data_stream_tfirst,
    output logic [NUM_CHANNELS-1:0]                  m_data_stream_tlast,

    output logic [NUM_CHANNELS*CNT_WIDTH-1:0]        stat_pkt_count,
    output logic [CNT_WIDTH-1:0]                     stat_drop_count
);

    localparam int CH_W = $clog2(NUM_CHANNELS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_META = 2'd1,
        ST_DATA = 2'd2,
        ST_DROP = 2'd3
    } state_t;

    state_t                     r_state;
    logic [UDP_PORT_WIDTH-1:0]  r_tbl_port [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0]    r_tbl_en;
    logic                       r_cfg_ready;
    logic                       r_meta_ready;
    logic [NUM_CHANNELS-1:0]    r_m_meta_valid;
    logic [CH_W-1:0]            r_ch;
    logic [IP_ADDR_WIDTH-1:0]   r_ip_addr;
    logic [UDP_PORT_WIDTH-1:0]  r_dst_port;
    logic [UDP_PORT_WIDTH-1:0]  r_src_port;
    logic [UDP_LEN_WIDTH-1:0]   r_data_len;

    logic                       w_hit;
    logic [CH_W-1:0]            w_hit_ch;
    logic                       w_meta_acc;
    logic                       w_last_acc;

    assign w_meta_acc = s_udp_meta_valid && r_meta_ready;
    assign w_last_acc = s_data_stream_tvalid && s_data_stream_tready && s_data_stream_tlast;

    // Descending scan so the lowest matching index is the one that sticks.
    always_comb begin
        w_hit    = 1'b0;
        w_hit_ch = '0;
        for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
            if (r_tbl_en[i] && (r_tbl_port[i] == s_udp_meta_dst_port)) begin
                w_hit    = 1'b1;
                w_hit_ch = CH_W'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cfg_ready <= 1'b0;
            r_tbl_en    <= '0;
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                r_tbl_port[i] <= '0;
            end
        end else begin
            r_cfg_ready <= 1'b1;
            if (s_port_cfg_valid && r_cfg_ready) begin
                for (int i = 0; i < NUM_CHANNELS; i++) begin
                    if (s_port_cfg_index == CH_W'(i)) begin
                        r_tbl_port[i] <= s_port_cfg_port;
                        r_tbl_en[i]   <= s_port_cfg_enable;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= ST_IDLE;
            r_meta_ready   <= 1'b0;
            r_m_meta_valid <= '0;
            r_ch           <= '0;
            r_ip_addr      <= '0;
            r_dst_port     <= '0;
            r_src_port     <= '0;
            r_data_len     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_meta_ready <= 1'b1;
                    if (w_meta_acc) begin
                        r_meta_ready <= 1'b0;
                        r_ip_addr    <= s_udp_meta_ip_addr;
                        r_dst_port   <= s_udp_meta_dst_port;
                        r_src_port   <= s_udp_meta_src_port;
                        r_data_len   <= s_udp_meta_data_len;
                        r_ch         <= w_hit_ch;
                        if (w_hit) begin
                            r_m_meta_valid <= NUM_CHANNELS'(1) << w_hit_ch;
                            r_state        <= ST_META;
                        end else begin
                            r_state        <= ST_DROP;
                        end
                    end
                end
                ST_META: begin
                    if (|(r_m_meta_valid & m_udp_meta_ready)) begin
                        r_m_meta_valid <= '0;
                        r_state        <= ST_DATA;
                    end
                end
                ST_DATA, ST_DROP: begin
                    if (w_last_acc) begin
                        r_meta_ready <= 1'b1;
                        r_state      <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign s_port_cfg_ready = r_cfg_ready;
    assign s_udp_meta_ready = r_meta_ready;
    assign m_udp_meta_valid = r_m_meta_valid;

    always_comb begin
        s_data_stream_tready = 1'b0;
        case (r_state)
            ST_DATA: s_data_stream_tready = m_data_stream_tready[r_ch];
            ST_DROP: s_data_stream_tready = 1'b1;
            default: s_data_stream_tready = 1'b0;
        endcase
    end

    for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_chan
        assign m_udp_meta_ip_addr [i*IP_ADDR_WIDTH  +: IP_ADDR_WIDTH]  = r_ip_addr;
        assign m_udp_meta_dst_port[i*UDP_PORT_WIDTH +: UDP_PORT_WIDTH] = r_dst_port;
        assign m_udp_meta_src_port[i*UDP_PORT_WIDTH +: UDP_PORT_WIDTH] = r_src_port;
        assign m_udp_meta_data_len[i*UDP_LEN_WIDTH  +: UDP_LEN_WIDTH]  = r_data_len;
        assign m_data_stream_tvalid[i] = (r_state == ST_DATA) && (r_ch == CH_W'(i))
                                         && s_data_stream_tvalid;
        assign m_data_stream_tdata[i*DATA_WIDTH +: DATA_WIDTH] = s_data_stream_tdata;
        assign m_data_stream_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH] = s_data_stream_tkeep;
        assign m_data_stream_tfirst[i] = s_data_stream_tfirst;
        assign m_data_stream_tlast[i]  = s_data_stream_tlast;
    end

`ifdef UDP_RX_DEMUX_STATS_EN
    logic [CNT_WIDTH-1:0] r_pkt_cnt [NUM_CHANNELS];
    logic [CNT_WIDTH-1:0] r_drop_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_drop_cnt <= '0;
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                r_pkt_cnt[i] <= '0;
            end
        end else if (w_last_acc) begin
            if (r_state == ST_DATA) begin
                r_pkt_cnt[r_ch] <= r_pkt_cnt[r_ch] + 1'b1;
            end else if (r_state == ST_DROP) begin
                r_drop_cnt <= r_drop_cnt + 1'b1;
            end
        end
    end

    for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_stat
        assign stat_pkt_count[i*CNT_WIDTH +: CNT_WIDTH] = r_pkt_cnt[i];
    end
    assign stat_drop_count = r_drop_cnt;
`else
    assign stat_pkt_count  = '0;
    assign stat_drop_count = '0;
`endif

endmodule

`default_nettype wire
